ntt_pass_sched: RTL

//  Sequences the two-pass 2^24 NTT over the 2^12-point core (ntt_top).

---
 rtl/ntt_sched_pkg.sv | 25 ++
 rtl/ntt_credit_ctr.sv | 33 +++
 rtl/ntt_pass_sched.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ntt_sched_pkg.sv
`default_nettype none
// ntt_sched_pkg -- shared state encoding and sizing helpers for the NTT pass scheduler (rev 1.0)

package ntt_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FEED   = 3'd1,
    DRAIN  = 3'd2,
    SWITCH = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Beats per core NTT: 2^nlevel points, 2*nlane points per beat.
  function automatic int beats_f(input int nlevel, input int nlane);
    return (1 << nlevel) / (2 * nlane);
  endfunction

  function automatic int cnt_w_f(input int nntt_w, input int nlevel, input int nlane);
    return nntt_w + $clog2(beats_f(nlevel, nlane));
  endfunction

endpackage

`default_nettype wire

// File: rtl/ntt_credit_ctr.sv
`default_nettype none
// ntt_credit_ctr -- saturating up/down credit counter for the output sink (rev 1.0)

module ntt_credit_ctr #(
  parameter int MAX = 512,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up,
  input  logic         down,
  output logic [W-1:0] count,
  output logic         sat_err
);

  logic at_max;

  assign at_max  = (count == W'(MAX));
  assign sat_err = up & ~down & at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= W'(MAX);
    end else if (up && !down) begin
      if (!at_max) count <= count + 1'b1;
    end else if (down && !up && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ntt_pass_sched.sv
`default_nettype none
// ntt_pass_sched -- feeds both passes of the 2^24 NTT into the 2^12-point core with sink-credit flow control (rev 1.0)

module ntt_pass_sched
  import ntt_sched_pkg::*;
#(
  parameter int NLEVEL      = 12,
  parameter int NLANE       = 8,
  parameter int NNTT_W      = 13,
  parameter int OUT_CREDITS = 512,
  parameter int SW_GAP      = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [NNTT_W-1:0] cfg_nntt_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass1_o,
  input  logic              src_valid_i,
  output logic              src_ready_o,
  output logic [NLANE-1:0]  ntt_valid_o,
  input  logic [NLANE-1:0]  ntt_valid_i,
  input  logic              snk_pop_i,
  output logic              err_o
);

  localparam int BEATS = beats_f(NLEVEL, NLANE);
  localparam int CNT_W = cnt_w_f(NNTT_W, NLEVEL, NLANE);
  localparam int CR_W  = $clog2(OUT_CREDITS + 1);
  localparam int GAP_W = (SW_GAP > 1) ? $clog2(SW_GAP) : 1;

  state_t            state;
  logic [CNT_W-1:0]  total;
  logic [CNT_W-1:0]  issued;
  logic [CNT_W-1:0]  outcnt;
  logic [GAP_W-1:0]  gap;
  logic [CR_W-1:0]   credits;
  logic              cr_err;
  logic              fire;
  logic              out_beat;
  logic              lane_bad;
  logic              beat_err;

  // The core cannot stall, so a beat is only admitted if the sink has room for its result.
  assign src_ready_o = (state == FEED) && (issued < total) && (credits != '0);
  assign fire        = src_valid_i & src_ready_o;
  assign ntt_valid_o = {NLANE{fire}};

  assign out_beat = ntt_valid_i[0];
  assign lane_bad = (ntt_valid_i != '0) && (ntt_valid_i != '1);
  assign beat_err = out_beat && ((state == IDLE) || (state == SWITCH) || (outcnt == total));

  ntt_credit_ctr #(
    .MAX (OUT_CREDITS),
    .W   (CR_W)
  ) u_credit (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .up      (snk_pop_i),
    .down    (fire),
    .count   (credits),
    .sat_err (cr_err)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      total   <= '0;
      issued  <= '0;
      outcnt  <= '0;
      gap     <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      pass1_o <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (out_beat) outcnt <= outcnt + 1'b1;
      if (beat_err || lane_bad || cr_err) err_o <= 1'b1;

      case (state)
        IDLE: begin
          if (start_i) begin
            total   <= CNT_W'(cfg_nntt_i) * CNT_W'(BEATS);
            issued  <= '0;
            outcnt  <= '0;
            pass1_o <= 1'b0;
            busy_o  <= 1'b1;
            state   <= (cfg_nntt_i == '0) ? DONE : FEED;
          end
        end
        FEED: begin
          if (fire) begin
            issued <= issued + 1'b1;
            if ((issued + 1'b1) == total) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (outcnt == total) begin
            if (pass1_o) begin
              state <= DONE;
            end else begin
              pass1_o <= 1'b1;
              issued  <= '0;
              outcnt  <= '0;
              gap     <= '0;
              state   <= SWITCH;
            end
          end
        end
        SWITCH: begin
          if (gap == GAP_W'(SW_GAP - 1)) state <= FEED;
          else                           gap   <= gap + 1'b1;
        end
        DONE: begin
          done_o  <= 1'b1;
          busy_o  <= 1'b0;
          pass1_o <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
